// File: rtl/sobel_edge_detect_if.sv
// Video window stream into the Sobel stage and the filtered pixel stream out of it.
// Master drives the window taps and controls; slave is the filter.
interface sobel_edge_detect_if;
   logic       matrix_vs;
   logic       matrix_hs;
   logic       matrix_de;
   logic [7:0] matrix_p11, matrix_p12, matrix_p13;
   logic [7:0] matrix_p21, matrix_p22, matrix_p23;
   logic [7:0] matrix_p31, matrix_p32, matrix_p33;
   logic [7:0] threshold;
   logic       mode;
   logic       sobel_vs;
   logic       sobel_hs;
   logic       sobel_de;
   logic [7:0] sobel_data;

   modport master (
      output matrix_vs, matrix_hs, matrix_de,
      output matrix_p11, matrix_p12, matrix_p13,
      output matrix_p21, matrix_p22, matrix_p23,
      output matrix_p31, matrix_p32, matrix_p33,
      output threshold, mode,
      input  sobel_vs, sobel_hs, sobel_de, sobel_data
   );

   modport slave (
      input  matrix_vs, matrix_hs, matrix_de,
      input  matrix_p11, matrix_p12, matrix_p13,
      input  matrix_p21, matrix_p22, matrix_p23,
      input  matrix_p31, matrix_p32, matrix_p33,
      input  threshold, mode,
      output sobel_vs, sobel_hs, sobel_de, sobel_data
   );
endinterface

// File: rtl/sobel_edge_detect.sv
// Sobel |Gx|+|Gy| edge filter: binary edge map or saturated magnitude, 3-cycle latency.
// Free-running pipeline, never stalls; the input stream has no backpressure.
module sobel_edge_detect #(
   parameter int CNT_W  = 12,
   parameter bit VS_POL = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   sobel_edge_detect_if.slave vid
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             vs_prev_q, vs_prev_d;
   logic             de_prev_q, de_prev_d;
   logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
   logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
   logic [7:0]       thr_q, thr_d;
   logic             mode_q, mode_d;
   logic [9:0]       gx_p_q, gx_p_d, gx_n_q, gx_n_d;
   logic [9:0]       gy_p_q, gy_p_d, gy_n_q, gy_n_d;
   logic [9:0]       ax_q, ax_d, ay_q, ay_d;
   logic [7:0]       data_q, data_d;
   logic [2:0]       vs_sr_q, vs_sr_d;
   logic [2:0]       hs_sr_q, hs_sr_d;
   logic [2:0]       de_sr_q, de_sr_d;
   logic [1:0]       ok_sr_q, ok_sr_d;

   logic             vs_act;
   logic             frame_start;
   logic             win_ok;
   logic [10:0]      mag;
   logic [7:0]       sat;

   always_comb begin
      vs_act      = (vid.matrix_vs == VS_POL);
      frame_start = vs_act && (vs_prev_q != VS_POL);
      vs_prev_d   = vid.matrix_vs;
      de_prev_d   = vid.matrix_de;

      thr_d  = thr_q;
      mode_d = mode_q;
      if (frame_start) begin
         thr_d  = vid.threshold;
         mode_d = vid.mode;
      end

      col_cnt_d = '0;
      if (vid.matrix_de)
         col_cnt_d = (col_cnt_q == CNT_MAX) ? col_cnt_q : col_cnt_q + 1'b1;

      row_cnt_d = row_cnt_q;
      if (vs_act)
         row_cnt_d = '0;
      else if (de_prev_q && !vid.matrix_de && (row_cnt_q != CNT_MAX))
         row_cnt_d = row_cnt_q + 1'b1;

      // Uses the pre-increment counts: the third pixel of the third line is the first full window.
      win_ok = vid.matrix_de && (col_cnt_q >= CNT_W'(2)) && (row_cnt_q >= CNT_W'(2));

      gx_p_d = {2'b00, vid.matrix_p13} + {1'b0, vid.matrix_p23, 1'b0} + {2'b00, vid.matrix_p33};
      gx_n_d = {2'b00, vid.matrix_p11} + {1'b0, vid.matrix_p21, 1'b0} + {2'b00, vid.matrix_p31};
      gy_p_d = {2'b00, vid.matrix_p11} + {1'b0, vid.matrix_p12, 1'b0} + {2'b00, vid.matrix_p13};
      gy_n_d = {2'b00, vid.matrix_p31} + {1'b0, vid.matrix_p32, 1'b0} + {2'b00, vid.matrix_p33};

      ax_d = (gx_p_q >= gx_n_q) ? (gx_p_q - gx_n_q) : (gx_n_q - gx_p_q);
      ay_d = (gy_p_q >= gy_n_q) ? (gy_p_q - gy_n_q) : (gy_n_q - gy_p_q);

      mag = {1'b0, ax_q} + {1'b0, ay_q};
      sat = (mag > 11'd255) ? 8'hFF : mag[7:0];

      data_d = 8'h00;
      if (de_sr_q[1] && ok_sr_q[1]) begin
         if (mode_q)
            data_d = sat;
         else if (mag > {3'b000, thr_q})
            data_d = 8'hFF;
      end

      vs_sr_d = {vs_sr_q[1:0], vid.matrix_vs};
      hs_sr_d = {hs_sr_q[1:0], vid.matrix_hs};
      de_sr_d = {de_sr_q[1:0], vid.matrix_de};
      ok_sr_d = {ok_sr_q[0], win_ok};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_prev_q <= 1'b0;
         de_prev_q <= 1'b0;
         col_cnt_q <= '0;
         row_cnt_q <= '0;
         thr_q     <= 8'h00;
         mode_q    <= 1'b0;
         gx_p_q    <= '0;
         gx_n_q    <= '0;
         gy_p_q    <= '0;
         gy_n_q    <= '0;
         ax_q      <= '0;
         ay_q      <= '0;
         data_q    <= 8'h00;
         vs_sr_q   <= '0;
         hs_sr_q   <= '0;
         de_sr_q   <= '0;
         ok_sr_q   <= '0;
      end else begin
         vs_prev_q <= vs_prev_d;
         de_prev_q <= de_prev_d;
         col_cnt_q <= col_cnt_d;
         row_cnt_q <= row_cnt_d;
         thr_q     <= thr_d;
         mode_q    <= mode_d;
         gx_p_q    <= gx_p_d;
         gx_n_q    <= gx_n_d;
         gy_p_q    <= gy_p_d;
         gy_n_q    <= gy_n_d;
         ax_q      <= ax_d;
         ay_q      <= ay_d;
         data_q    <= data_d;
         vs_sr_q   <= vs_sr_d;
         hs_sr_q   <= hs_sr_d;
         de_sr_q   <= de_sr_d;
         ok_sr_q   <= ok_sr_d;
      end
   end

   assign vid.sobel_vs   = vs_sr_q[2];
   assign vid.sobel_hs   = hs_sr_q[2];
   assign vid.sobel_de   = de_sr_q[2];
   assign vid.sobel_data = data_q;

endmodule
